// File: rtl/imem_fetch_port.sv
// Core-side initiator for the shared instruction-memory arbiter: one beat per request.
// Optional grant-wait timeout is enabled by defining IMEM_TIMEOUT_EN.
module imem_fetch_port #(
  parameter int unsigned CORE_ID        = 0,
  parameter int unsigned RAM_LAT        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [7:0]  wdata,
  output logic        ready,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        rden,
  output logic        wren,
  output logic [7:0]  addr_lane,
  output logic [7:0]  din_lane,
  input  logic        acq,
  input  logic [31:0] dq
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StRelease} state_e;

  state_e      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rden_q, rden_d;
  logic        wren_q, wren_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        lat_hit;
  logic        tmo_hit;
  logic [7:0]  dq_lane;
  logic        unused_dq;

  assign lat_hit   = (lat_q == 4'(RAM_LAT - 1));
  assign dq_lane   = dq[8*CORE_ID +: 8];
  assign unused_dq = ^dq;

`ifdef IMEM_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Counts only while staying in REQ, so every entry into REQ starts from zero.
  always_comb begin
    tmo_d = '0;
    if (state_q == StReq && state_d == StReq) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lat_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rden_q  <= rden_d;
      wren_q  <= wren_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req) state_d = StReq;
      StReq: begin
        if (acq) begin
          state_d = StWait;
        end else if (tmo_hit) begin
          state_d = StRelease;
        end
      end
      // A revoked grant takes priority over a latency match.
      StWait: begin
        if (!acq) begin
          state_d = StReq;
        end else if (lat_hit) begin
          state_d = StRelease;
        end
      end
      StRelease: if (!acq) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_d = (state_d == StIdle);
    done_d  = (state_q == StWait) && acq && lat_hit;
    err_d   = (state_q == StReq) && !acq && tmo_hit;
    lat_d   = lat_q;
    rden_d  = rden_q;
    wren_d  = wren_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    din_d   = din_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d = addr;
          din_d  = wdata;
          rden_d = ~we;
          wren_d = we;
        end
      end
      StReq: begin
        lat_d = '0;
        if (!acq && tmo_hit) begin
          rden_d = 1'b0;
          wren_d = 1'b0;
        end
      end
      StWait: begin
        if (acq) begin
          if (lat_hit) begin
            if (rden_q) rdata_d = dq_lane;
            rden_d = 1'b0;
            wren_d = 1'b0;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
      end
      StRelease: begin
        rden_d = 1'b0;
        wren_d = 1'b0;
      end
      default: begin
        rden_d = 1'b0;
        wren_d = 1'b0;
      end
    endcase
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rden      = rden_q;
  assign wren      = wren_q;
  assign rdata     = rdata_q;
  assign addr_lane = addr_q;
  assign din_lane  = din_q;

endmodule
